// File: rtl/pong_pkg.sv
`default_nettype none
// pong_pkg: select encodings, screen bounds and the reader state type shared by
// pong_state_reader and pong_step_pulser.
package pong_pkg;

   localparam int SCREEN_WIDTH_DEF  = 200;
   localparam int SCREEN_HEIGHT_DEF = 187;

   localparam logic [1:0] SEL_BALL_X = 2'd0;
   localparam logic [1:0] SEL_BALL_Y = 2'd1;
   localparam logic [1:0] SEL_LPAD   = 2'd2;
   localparam logic [1:0] SEL_RPAD   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRIVE   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_PRESENT = 3'd5
   } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/pong_step_pulser.sv
`default_nettype none
// pong_step_pulser: on go, holds step high for PULSE_W cycles, waits SETTLE_CYCLES,
// then emits a one-cycle sample strobe. last flags the final cycle of each timed phase.
module pong_step_pulser
   import pong_pkg::*;
#(
   parameter int PULSE_W       = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic go,
   output logic step,
   output logic last,
   output logic sample
);

   localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_W - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   reader_state_t phase;
   logic [3:0]    timer;

   assign last = (timer == 4'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase  <= ST_IDLE;
         step   <= 1'b0;
         timer  <= 4'd0;
         sample <= 1'b0;
      end else begin
         sample <= 1'b0;
         case (phase)
            ST_IDLE: begin
               if (go) begin
                  phase <= ST_PULSE;
                  step  <= 1'b1;
                  timer <= PULSE_LOAD;
               end
            end
            ST_PULSE: begin
               if (last) begin
                  phase <= ST_SETTLE;
                  step  <= 1'b0;
                  timer <= SETTLE_LOAD;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            ST_SETTLE: begin
               if (last) begin
                  phase  <= ST_IDLE;
                  sample <= 1'b1;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            default: begin
               phase <= ST_IDLE;
               step  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/pong_state_reader.sv
`default_nettype none
// pong_state_reader: walks the core's four state bytes and presents them as one snapshot.
// Define PONG_READER_AUTO_EN to chain snapshots back to back after each handshake.
module pong_state_reader
   import pong_pkg::*;
#(
   parameter int PULSE_W       = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
   parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic [1:0] sel,
   output logic       step,
   input  logic [7:0] data_in,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic [7:0] ball_x,
   output logic [7:0] ball_y,
   output logic [7:0] lpad_y,
   output logic [7:0] rpad_y,
   output logic       range_err
);

   localparam logic [8:0] X_LIMIT = 9'(SCREEN_WIDTH);
   localparam logic [8:0] Y_LIMIT = 9'(SCREEN_HEIGHT);

   reader_state_t state;
   logic [1:0]    field;
   logic          go;
   logic          last;
   logic          sample;

   // sel only moves when field is reloaded on entry to DRIVE
   assign sel = field;
   assign go  = (state == ST_DRIVE);

   pong_step_pulser #(
      .PULSE_W       (PULSE_W),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_pulser (
      .clk    (clk),
      .rst_n  (rst_n),
      .go     (go),
      .step   (step),
      .last   (last),
      .sample (sample)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         field      <= SEL_BALL_X;
         busy       <= 1'b0;
         snap_valid <= 1'b0;
         range_err  <= 1'b0;
         ball_x     <= 8'd0;
         ball_y     <= 8'd0;
         lpad_y     <= 8'd0;
         rpad_y     <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_DRIVE;
                  field <= SEL_BALL_X;
                  busy  <= 1'b1;
               end
            end
            ST_DRIVE: state <= ST_PULSE;
            ST_PULSE: begin
               if (last) state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (last) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (sample) begin
                  case (field)
                     SEL_BALL_X: ball_x <= data_in;
                     SEL_BALL_Y: ball_y <= data_in;
                     SEL_LPAD:   lpad_y <= data_in;
                     default:    rpad_y <= data_in;
                  endcase
                  if (field == SEL_RPAD) begin
                     state      <= ST_PRESENT;
                     snap_valid <= 1'b1;
                     range_err  <= ({1'b0, ball_x} >= X_LIMIT) ||
                                   ({1'b0, ball_y} >= Y_LIMIT);
                  end else begin
                     field <= field + 2'd1;
                     state <= ST_DRIVE;
                  end
               end
            end
            ST_PRESENT: begin
               if (snap_ready) begin
                  snap_valid <= 1'b0;
`ifdef PONG_READER_AUTO_EN
                  state      <= ST_DRIVE;
                  field      <= SEL_BALL_X;
`else
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
`endif
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/pong_state_reader.md
Name: pong_state_reader

Overview:
- Host-side reader for the pong core's multiplexed state-byte interface.
- Drives the core's 2-bit output select and its step clock, waits for the registered byte to settle, captures it, then moves to the next field.
- After four fields it presents one complete state snapshot (ball x/y, left/right paddle y) on a valid/ready interface, with a range-check flag.
- Sits between the pong core's pins and any consumer (display renderer, logger, scoring logic).

Parameters:
- PULSE_W, 2, number of clk cycles the step output is held high (range 1..15).
- SETTLE_CYCLES, 2, number of clk cycles after step falls before data_in is sampled (covers pad and synchroniser delay; range 1..15).
- SCREEN_WIDTH, 200, exclusive upper bound for a legal ball_x.
- SCREEN_HEIGHT, 187, exclusive upper bound for a legal ball_y.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request one snapshot; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- sel  out  2  field select to the core: 0 = ball_x, 1 = ball_y, 2 = left paddle, 3 = right paddle.
- step  out  1  step clock to the core.
- data_in  in  8  byte returned by the core.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts the snapshot.
- ball_x  out  8  captured field 0.
- ball_y  out  8  captured field 1.
- lpad_y  out  8  captured field 2.
- rpad_y  out  8  captured field 3.
- range_err  out  1  ball_x >= SCREEN_WIDTH or ball_y >= SCREEN_HEIGHT in the current snapshot.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; sel = 0; step = 0; busy = 0; snap_valid = 0; range_err = 0; all four field registers = 0.
  - The field counter and timers clear.
  - Reset mid-operation abandons the partial snapshot; step drops low at that same edge.
- States: IDLE, DRIVE, PULSE, SETTLE, CAPTURE, PRESENT.
- IDLE:
  - start = 1 moves to DRIVE with field counter = 0.
  - start = 0 stays in IDLE.
- DRIVE: 1 cycle; sel = field counter, step = 0; moves to PULSE.
- PULSE: step = 1 for exactly PULSE_W cycles; sel held; moves to SETTLE.
- SETTLE: step = 0 for SETTLE_CYCLES cycles; moves to CAPTURE.
- CAPTURE: 1 cycle; data_in is registered into the field selected by the counter.
  - If counter = 3: moves to PRESENT; range_err is computed from the captured ball_x/ball_y and registered on the same edge as snap_valid.
  - Otherwise: counter increments and the state returns to DRIVE.
- PRESENT:
  - snap_valid = 1; all field outputs and range_err are held stable.
  - snap_valid & snap_ready moves to IDLE and clears snap_valid at that edge.
  - Fields keep their values until the next CAPTURE overwrites them.
- sel changes only on entry to DRIVE. It never changes while step = 1 or during SETTLE.
- Latency:
  - Each field takes 2 + PULSE_W + SETTLE_CYCLES cycles.
  - snap_valid rises 4*(2 + PULSE_W + SETTLE_CYCLES) + 1 edges after the edge that samples start (25 edges with defaults).
- Semantics: the core registers its output on the step edge, so the byte captured for field k is that field's value before this step. Each field read advances the game one tick; a snapshot costs four ticks. This is intended.
- start outside IDLE (including PRESENT) is ignored; it is neither queued nor counted.
- snap_ready outside PRESENT is ignored.
- Comparisons are unsigned 8-bit. The boundaries ball_x = 199 and ball_y = 186 are legal.
- Timer counters are 4-bit and saturate-free: the parameter range guarantees no wrap.

Optional Feature:
- Macro PONG_READER_AUTO_EN.
- When defined: the FSM leaves PRESENT on handshake and goes directly to DRIVE with counter = 0 (continuous snapshots, no IDLE cycle). The start port is still honoured in IDLE, e.g. after reset.
- When undefined: every snapshot needs a start pulse as described above.

Decomposition:
- Shared package pong_pkg holds:
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults;
  - select encoding constants SEL_BALL_X = 0, SEL_BALL_Y = 1, SEL_LPAD = 2, SEL_RPAD = 3;
  - the reader state enum typedef.
- One natural sub-module, pong_step_pulser: given a go strobe, it runs DRIVE/PULSE/SETTLE timing, drives step, and returns a one-cycle sample strobe. The top keeps the field counter, the field registers and the handshake.

Test Plan:
- Core stub returns 10/20/30/40 for sel 0/1/2/3; pulse start -> exactly 4 step pulses each 2 cycles wide; snap_valid rises at edge 25; ball_x = 10, ball_y = 20, lpad_y = 30, rpad_y = 40; range_err = 0.
- Stub ball_x = 200, ball_y = 186 -> range_err = 1; then ball_x = 199, ball_y = 187 -> range_err = 1; then ball_x = 199, ball_y = 186 -> range_err = 0.
- Hold snap_ready = 0 for 50 cycles while the stub changes data_in -> outputs stable, snap_valid held, no step pulses; raise ready -> IDLE on the next edge.
- Start held high continuously -> only one snapshot per IDLE visit; start asserted during PULSE has no effect on the step count.
- rst_n low for 1 cycle during PULSE of field 2 -> step = 0, busy = 0, all fields = 0 on the next cycle; a fresh start yields a full correct snapshot.
- With PONG_READER_AUTO_EN: one start plus snap_ready tied high -> back-to-back snapshots every 25 cycles and no IDLE cycle. Without the macro -> a single snapshot, then idle.
